// File: rtl/iterative_mul_unit_pkg.sv
// Shared RV32 uop encoding plus the operand-preparation helpers used by the
// iterative multiply execute pipe.
package iterative_mul_unit_pkg;

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_SLL, OP_SLT, OP_SLTU, OP_XOR, OP_SRL, OP_SRA,
    OP_OR, OP_AND, OP_LUI, OP_AUIPC,
    OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU
  } rv_uop;

  localparam int unsigned p_num_uops = 16;
  typedef logic [p_num_uops-1:0] rv_uop_set;

  // Decode routes exactly this subset of uops to the multiply pipe.
  localparam rv_uop_set p_tinyrv_mul =
      (rv_uop_set'(1) << OP_MUL)    | (rv_uop_set'(1) << OP_MULH) |
      (rv_uop_set'(1) << OP_MULHSU) | (rv_uop_set'(1) << OP_MULHU);

  typedef struct packed {
    logic [31:0] mag1;
    logic [31:0] mag2;
    logic        neg;
  } mul_operands_t;

  function automatic logic uop_in_set(rv_uop_set set, rv_uop uop);
    return set[uop];
  endfunction

  // Any uop that is not one of the high-half forms is handled as MUL.
  function automatic logic uop_selects_high(rv_uop uop);
    return uop inside {OP_MULH, OP_MULHSU, OP_MULHU};
  endfunction

  // The datapath multiplies unsigned magnitudes; the sign is reapplied at the end.
  function automatic mul_operands_t prep_operands(rv_uop uop, logic [31:0] op1,
                                                  logic [31:0] op2);
    mul_operands_t ops;
    logic          s1;
    logic          s2;
    s1       = (uop != OP_MULHU) & op1[31];
    s2       = !(uop inside {OP_MULHSU, OP_MULHU}) & op2[31];
    ops.mag1 = s1 ? -op1 : op1;
    ops.mag2 = s2 ? -op2 : op2;
    ops.neg  = s1 ^ s2;
    return ops;
  endfunction

endpackage

// File: rtl/iterative_mul_unit_mul_step.sv
// One combinational shift-add step: consumes p_bits_per_cycle multiplier bits.
module iterative_mul_unit_mul_step #(
  parameter int unsigned p_bits_per_cycle = 1
) (
  input  logic [63:0] acc,
  input  logic [63:0] mcand,
  input  logic [31:0] mplier,
  output logic [63:0] acc_next,
  output logic [63:0] mcand_next,
  output logic [31:0] mplier_next
);

  logic [p_bits_per_cycle-1:0] digit;
  logic [63:0]                 partial;

  assign digit = mplier[p_bits_per_cycle-1:0];

  // NOTE: every variable written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    partial = '0;
    for (int i = 0; i < p_bits_per_cycle; i++) begin
      if (digit[i]) partial = partial + (mcand << i);
    end
  end

  assign acc_next    = acc + partial;
  assign mcand_next  = mcand << p_bits_per_cycle;
  assign mplier_next = mplier >> p_bits_per_cycle;

endmodule

// File: rtl/iterative_mul_unit.sv
// Multi-cycle RV32M multiply pipe: D->X issue handshake, shift-add datapath,
// X->W result handshake with pipelined accept while the result drains.
module iterative_mul_unit
  import iterative_mul_unit_pkg::*;
#(
  parameter int unsigned p_seq_num_bits   = 5,
  parameter int unsigned p_bits_per_cycle = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      D_val,
  output logic                      D_rdy,
  input  logic [31:0]               D_pc,
  input  logic [31:0]               D_op1,
  input  logic [31:0]               D_op2,
  input  rv_uop                     D_uop,
  input  logic [4:0]                D_waddr,
  input  logic [p_seq_num_bits-1:0] D_seq_num,
  output logic                      W_val,
  input  logic                      W_rdy,
  output logic [31:0]               W_pc,
  output logic [p_seq_num_bits-1:0] W_seq_num,
  output logic [4:0]                W_waddr,
  output logic [31:0]               W_wdata,
  output logic                      W_wen
);

  localparam int unsigned p_num_steps = 32 / p_bits_per_cycle;
  localparam int unsigned p_cnt_bits  = (p_num_steps > 1) ? $clog2(p_num_steps) : 1;

  if (!(p_bits_per_cycle inside {1, 2, 4, 8})) begin : g_bad_radix
    $error("p_bits_per_cycle must be 1, 2, 4 or 8");
  end

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t                    state;
  state_t                    state_next;
  logic                      d_xfer;
  mul_operands_t             ops;
  logic [31:0]               pc_q;
  logic [4:0]                waddr_q;
  logic [p_seq_num_bits-1:0] seq_q;
  logic                      high_q;
  logic                      neg_q;
  logic [p_cnt_bits-1:0]     cnt_q;
  logic [63:0]               acc_q;
  logic [63:0]               mcand_q;
  logic [31:0]               mplier_q;
  logic [63:0]               acc_step;
  logic [63:0]               mcand_step;
  logic [31:0]               mplier_step;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // D_rdy depends only on state and W_rdy, never on D_val.
  always_comb begin
    state_next = state;
    D_rdy      = 1'b0;
    W_val      = 1'b0;
    unique case (state)
      IDLE: begin
        D_rdy = 1'b1;
        if (D_val) state_next = CALC;
      end
      CALC: begin
        if (cnt_q == '0) state_next = DONE;
      end
      DONE: begin
        W_val = 1'b1;
        D_rdy = W_rdy;
        if (W_rdy) state_next = D_val ? CALC : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign d_xfer = D_val & D_rdy;
  assign ops    = prep_operands(D_uop, D_op1, D_op2);

  iterative_mul_unit_mul_step #(
    .p_bits_per_cycle(p_bits_per_cycle)
  ) u_step (
    .acc        (acc_q),
    .mcand      (mcand_q),
    .mplier     (mplier_q),
    .acc_next   (acc_step),
    .mcand_next (mcand_step),
    .mplier_next(mplier_step)
  );

  // NOTE: datapath registers have no reset; the FSM never exposes them before a load.
  always_ff @(posedge clk) begin
    if (d_xfer) begin
      pc_q     <= D_pc;
      waddr_q  <= D_waddr;
      seq_q    <= D_seq_num;
      high_q   <= uop_selects_high(D_uop);
      neg_q    <= ops.neg;
      cnt_q    <= p_cnt_bits'(p_num_steps - 1);
      acc_q    <= '0;
      mcand_q  <= {32'b0, ops.mag1};
      mplier_q <= ops.mag2;
    end else if (state == CALC) begin
      // The sign is reapplied on the final step, as the result enters DONE.
      acc_q    <= (cnt_q == '0 && neg_q) ? -acc_step : acc_step;
      mcand_q  <= mcand_step;
      mplier_q <= mplier_step;
      cnt_q    <= cnt_q - 1'b1;
    end
  end

  assign W_pc      = pc_q;
  assign W_seq_num = seq_q;
  assign W_waddr   = waddr_q;
  assign W_wdata   = high_q ? acc_q[63:32] : acc_q[31:0];
  assign W_wen     = W_val;

  a_mul_uop_only: assert property (@(posedge clk) disable iff (!rst)
    d_xfer |-> uop_in_set(p_tinyrv_mul, D_uop))
    else $error("non-multiply uop issued to iterative_mul_unit");

  function automatic string line_trace();
    return $sformatf("%s:%0d", state.name(), seq_q);
  endfunction

endmodule

// File: tb/tb_iterative_mul_unit.sv
// Directed and randomized checks for iterative_mul_unit at radix 1 and radix 4.
module tb_iterative_mul_unit;
  import iterative_mul_unit_pkg::*;

  logic            clk;
  logic            rst;
  logic [1:0]      d_val, d_rdy, w_val, w_rdy, w_wen;
  logic [1:0][31:0] d_pc, d_op1, d_op2, w_pc, w_wdata;
  logic [1:0][4:0] d_waddr, d_seq, w_waddr, w_seq;
  rv_uop           d_uop [2];
  int              checks;
  int              errors;

  iterative_mul_unit #(.p_seq_num_bits(5), .p_bits_per_cycle(1)) dut_r1 (
    .clk(clk), .rst(rst),
    .D_val(d_val[0]), .D_rdy(d_rdy[0]), .D_pc(d_pc[0]), .D_op1(d_op1[0]),
    .D_op2(d_op2[0]), .D_uop(d_uop[0]), .D_waddr(d_waddr[0]), .D_seq_num(d_seq[0]),
    .W_val(w_val[0]), .W_rdy(w_rdy[0]), .W_pc(w_pc[0]), .W_seq_num(w_seq[0]),
    .W_waddr(w_waddr[0]), .W_wdata(w_wdata[0]), .W_wen(w_wen[0])
  );

  iterative_mul_unit #(.p_seq_num_bits(5), .p_bits_per_cycle(4)) dut_r4 (
    .clk(clk), .rst(rst),
    .D_val(d_val[1]), .D_rdy(d_rdy[1]), .D_pc(d_pc[1]), .D_op1(d_op1[1]),
    .D_op2(d_op2[1]), .D_uop(d_uop[1]), .D_waddr(d_waddr[1]), .D_seq_num(d_seq[1]),
    .W_val(w_val[1]), .W_rdy(w_rdy[1]), .W_pc(w_pc[1]), .W_seq_num(w_seq[1]),
    .W_waddr(w_waddr[1]), .W_wdata(w_wdata[1]), .W_wen(w_wen[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
    $fatal(1);
  end

  task automatic check(string tag, logic [63:0] got, logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic int latency(int u);
    return (u == 0) ? 33 : 9;
  endfunction

  function automatic logic [31:0] ref_mul(rv_uop uop, logic [31:0] a, logic [31:0] b);
    logic [63:0] sa;
    logic [63:0] sb;
    logic [63:0] p;
    sa = (uop == OP_MULHU) ? {32'b0, a} : {{32{a[31]}}, a};
    sb = (uop inside {OP_MULHU, OP_MULHSU}) ? {32'b0, b} : {{32{b[31]}}, b};
    p  = sa * sb;
    return (uop == OP_MUL) ? p[31:0] : p[63:32];
  endfunction

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 32'h0000_0000;
      1:       return 32'h0000_0001;
      2:       return 32'hFFFF_FFFF;
      3:       return 32'h8000_0000;
      4:       return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // Presents one op and returns just after the edge that transfers it.
  task automatic issue(int u, rv_uop uop, logic [31:0] a, logic [31:0] b,
                       logic [31:0] pc, logic [4:0] wa, logic [4:0] seq);
    int guard;
    guard = 0;
    while (!d_rdy[u] && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!d_rdy[u]) check("issue_timeout", 64'd0, 64'd1);
    d_val[u] = 1'b1; d_uop[u] = uop; d_op1[u] = a; d_op2[u] = b;
    d_pc[u] = pc; d_waddr[u] = wa; d_seq[u] = seq;
    @(posedge clk);
    #1 d_val[u] = 1'b0;
  endtask

  // Counts cycles after the transfer edge until W_val is seen (sampled on negedge).
  task automatic wait_result(int u, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!w_val[u] && n < 200);
    if (!w_val[u]) begin
      check("result_timeout", 64'd0, 64'd1);
      n = -1;
    end
  endtask

  task automatic receive(int u, string tag, logic [31:0] exp_data, logic [31:0] exp_pc,
                         logic [4:0] exp_wa, logic [4:0] exp_seq);
    int n;
    wait_result(u, n);
    check({tag, "_lat"}, 64'(n), 64'(latency(u)));
    check({tag, "_data"}, w_wdata[u], exp_data);
    check({tag, "_wen"}, w_wen[u], 1);
    check({tag, "_pc"}, w_pc[u], exp_pc);
    check({tag, "_waddr"}, w_waddr[u], exp_wa);
    check({tag, "_seq"}, w_seq[u], exp_seq);
  endtask

  typedef struct {
    rv_uop       uop;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [10];

  task automatic run_directed(int u);
    int n;
    int seen;
    logic [31:0] hold_data;
    // Basic MUL with metadata echo, then the unit returns to IDLE.
    w_rdy[u] = 1'b1;
    issue(u, OP_MUL, 32'd7, 32'd6, 32'h0000_1000, 5'd3, 5'd1);
    receive(u, $sformatf("u%0d_mul7x6", u), 32'd42, 32'h0000_1000, 5'd3, 5'd1);
    @(negedge clk);
    check($sformatf("u%0d_idle_wval", u), w_val[u], 0);
    check($sformatf("u%0d_idle_drdy", u), d_rdy[u], 1);

    for (int i = 0; i < 10; i++) begin
      issue(u, vecs[i].uop, vecs[i].a, vecs[i].b, 32'h100 + 32'(i * 4), 5'(i + 1), 5'(i + 2));
      receive(u, $sformatf("u%0d_vec%0d", u, i), vecs[i].exp, 32'h100 + 32'(i * 4),
              5'(i + 1), 5'(i + 2));
    end

    // Backpressure: hold the result for 10 cycles in DONE.
    @(negedge clk);
    w_rdy[u] = 1'b0;
    issue(u, OP_MULHU, 32'hDEAD_BEEF, 32'h0000_0010, 32'h0000_2000, 5'd9, 5'd7);
    wait_result(u, n);
    check($sformatf("u%0d_bp_lat", u), 64'(n), 64'(latency(u)));
    hold_data = 32'h0000_000D;
    for (int i = 0; i < 10; i++) begin
      check($sformatf("u%0d_bp_val%0d", u, i), w_val[u], 1);
      check($sformatf("u%0d_bp_data%0d", u, i), w_wdata[u], hold_data);
      check($sformatf("u%0d_bp_pc%0d", u, i), w_pc[u], 32'h0000_2000);
      check($sformatf("u%0d_bp_seq%0d", u, i), w_seq[u], 5'd7);
      check($sformatf("u%0d_bp_drdy%0d", u, i), d_rdy[u], 0);
      @(negedge clk);
    end
    w_rdy[u] = 1'b1;
    @(negedge clk);
    check($sformatf("u%0d_bp_after_wval", u), w_val[u], 0);
    check($sformatf("u%0d_bp_after_drdy", u), d_rdy[u], 1);
    @(negedge clk);
    check($sformatf("u%0d_bp_once", u), w_val[u], 0);

    // Back-to-back: the next op is accepted in the same cycle the result drains.
    w_rdy[u] = 1'b0;
    issue(u, OP_MUL, 32'd100, 32'd200, 32'h0000_3000, 5'd4, 5'd10);
    wait_result(u, n);
    check($sformatf("u%0d_b2b_a_lat", u), 64'(n), 64'(latency(u)));
    check($sformatf("u%0d_b2b_a_data", u), w_wdata[u], 32'd20000);
    check($sformatf("u%0d_b2b_a_seq", u), w_seq[u], 5'd10);
    w_rdy[u] = 1'b1;
    #1;
    check($sformatf("u%0d_b2b_accept", u), d_rdy[u], 1);
    issue(u, OP_MUL, 32'hFFFF_FFFF, 32'd5, 32'h0000_3004, 5'd5, 5'd11);
    receive(u, $sformatf("u%0d_b2b_b", u), 32'hFFFF_FFFB, 32'h0000_3004, 5'd5, 5'd11);

    // Reset in the middle of CALC discards the op.
    @(negedge clk);
    issue(u, OP_MUL, 32'd123, 32'd456, 32'h0000_4000, 5'd6, 5'd20);
    repeat ((u == 0) ? 10 : 5) @(negedge clk);
    check($sformatf("u%0d_calc_drdy", u), d_rdy[u], 0);
    #2 rst = 1'b0;
    #1 check($sformatf("u%0d_rst_wval", u), w_val[u], 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    seen = 0;
    repeat (40) begin
      @(negedge clk);
      if (w_val[u]) seen++;
    end
    check($sformatf("u%0d_rst_no_result", u), 64'(seen), 64'd0);
    check($sformatf("u%0d_rst_drdy", u), d_rdy[u], 1);
    issue(u, OP_MUL, 32'd3, 32'd5, 32'h0000_5000, 5'd7, 5'd21);
    receive(u, $sformatf("u%0d_post_rst", u), 32'd15, 32'h0000_5000, 5'd7, 5'd21);
    @(negedge clk);
  endtask

  task automatic run_random(int u, int n_ops);
    for (int i = 0; i < n_ops; i++) begin
      rv_uop       uop;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] pc;
      logic [4:0]  wa;
      uop = rv_uop'(int'(OP_MUL) + int'($urandom_range(0, 3)));
      a   = pick_operand();
      b   = pick_operand();
      pc  = $urandom;
      wa  = 5'($urandom);
      issue(u, uop, a, b, pc, wa, 5'(i));
      receive(u, $sformatf("u%0d_rnd%0d", u, i), ref_mul(uop, a, b), pc, wa, 5'(i));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    d_val = '0; w_rdy = '1; d_pc = '0; d_op1 = '0; d_op2 = '0;
    d_waddr = '0; d_seq = '0; d_uop[0] = OP_MUL; d_uop[1] = OP_MUL;
    vecs[0] = '{OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[1] = '{OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
    vecs[2] = '{OP_MULHSU, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF};
    vecs[3] = '{OP_MUL,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[4] = '{OP_MULH,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
    vecs[5] = '{OP_MULHSU, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    vecs[6] = '{OP_MULHU,  32'h0000_0000, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[7] = '{OP_MUL,    32'h1234_5678, 32'h0000_0000, 32'h0000_0000};
    vecs[8] = '{OP_MULH,   32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF};
    vecs[9] = '{OP_MUL,    32'hFFFF_FFFD, 32'h0000_0007, 32'hFFFF_FFEB};
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_wval_r1", w_val[0], 0);
    check("rst_wval_r4", w_val[1], 0);
    rst = 1'b1;
    #1;
    check("rst_drdy_r1", d_rdy[0], 1);
    check("rst_drdy_r4", d_rdy[1], 1);
    run_directed(0);
    run_directed(1);
    run_random(0, 200);
    run_random(1, 1000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/iterative_mul_unit.md
Name: iterative_mul_unit

Overview:
- Multi-cycle execute pipe directly downstream of the decode/issue unit.
- Accepts one RV32M multiply uop at a time over the D->X handshake and computes it with a shift-add datapath, p_bits_per_cycle product bits per cycle.
- Presents the result on the X->W handshake to writeback, which drives the completion notification back to decode.
- Decode routes only MUL/MULH/MULHSU/MULHU to this pipe via its pipe subset.

Parameters:
- p_seq_num_bits, 5: width of the instruction sequence number.
- p_bits_per_cycle, 1: multiplier bits consumed per CALC cycle; legal values 1, 2, 4, 8; N = 32 / p_bits_per_cycle CALC cycles.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; asynchronous, active-low (asserted when 0).
- D_val  in  1  issue request valid.
- D_rdy  out  1  unit can accept an issue.
- D_pc  in  32  instruction PC.
- D_op1  in  32  rs1 value.
- D_op2  in  32  rs2 value.
- D_uop  in  rv_uop  operation.
- D_waddr  in  5  destination register.
- D_seq_num  in  p_seq_num_bits  sequence number.
- W_val  out  1  result valid.
- W_rdy  in  1  writeback can accept.
- W_pc  out  32  PC of the result.
- W_seq_num  out  p_seq_num_bits  sequence number of the result.
- W_waddr  out  5  destination register.
- W_wdata  out  32  result.
- W_wen  out  1  write enable; always 1 while W_val.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; W_val=0; D_rdy=1 once rst deasserts.
  - Reset mid-CALC or mid-DONE discards the operation with no output.
- States and transitions:
  - IDLE: D_rdy=1, W_val=0. On D_xfer (D_val & D_rdy), latch pc, waddr, seq_num, uop and operands, then go to CALC.
  - CALC: D_rdy=0, W_val=0. Run N cycles under a down-counter, then go to DONE.
  - DONE: W_val=1 with latched metadata and the selected result. On W_val & W_rdy, go to IDLE.
- Pipelined accept in DONE:
  - D_rdy = (state==IDLE) | (state==DONE & W_rdy).
  - A D_xfer in the same cycle as a W_xfer loads the new op and goes directly to CALC.
  - D_rdy must not depend combinationally on D_val.
- Latency: for a D_xfer in cycle c, W_val first asserts in cycle c+N+1; for p_bits_per_cycle=1 that is c+33.
- Throughput: one op per N+1 cycles under W_rdy=1.
- Operand preparation at accept:
  - MUL and MULH: both operands signed.
  - MULHSU: op1 signed, op2 unsigned.
  - MULHU: both unsigned.
  - Store the magnitudes plus neg = sign1 XOR sign2.
- Datapath:
  - 64-bit accumulator.
  - 64-bit multiplicand shifted left p_bits_per_cycle each cycle.
  - 32-bit multiplier shifted right p_bits_per_cycle each cycle.
  - Each cycle, add multiplicand × (low p_bits_per_cycle multiplier bits).
- Result selection:
  - The product is negated (two's complement, 64-bit) on entering DONE if neg.
  - MUL returns product[31:0]; the other three return product[63:32].
- Stability: W_* outputs stay stable while W_val & !W_rdy (backpressure holds indefinitely).
- Illegal uop: a non-multiply uop is a simulation error (assertion); synthesis treats it as MUL.
- Operand 0: no early termination; latency stays fixed at N+1.

Decomposition:
- Shared ISA package:
  - OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU in rv_uop.
  - A p_tinyrv_mul subset constant for decode pipe routing.
- Local to this block: typedef enum for IDLE/CALC/DONE.
- Sub-module mul_step: one combinational shift-add step, parameterised by p_bits_per_cycle, instantiated once and iterated by the FSM.
- Linetrace: shows state and seq_num.

Test Plan:
- Basic MUL: MUL op1=7, op2=6, W_rdy=1 -> W_wdata=42, W_wen=1, W_val exactly 33 cycles after D_xfer, seq_num/waddr/pc echoed.
- Signed and mixed high halves:
  - MULH(0xFFFFFFFF, 0xFFFFFFFF) -> 0x00000000.
  - MULHU same operands -> 0xFFFFFFFE.
  - MULHSU(0xFFFFFFFF, 2) -> 0xFFFFFFFF.
  - MUL(0x80000000, 0xFFFFFFFF) -> 0x80000000.
- Backpressure: hold W_rdy=0 for 10 cycles in DONE -> W_val and W_* stable, D_rdy=0 throughout; release -> one transfer, then IDLE.
- Back-to-back: second op presented during the first op's DONE with W_rdy=1 -> accepted the same cycle; second result 33 cycles later; no bubble beyond N+1.
- Reset mid-op: drive rst=0 asynchronously at CALC cycle 10 -> W_val=0 immediately, no result emitted; after release D_rdy=1 and a fresh MUL(3, 5) returns 15.
- Radix sweep: rerun the above with p_bits_per_cycle=4 -> identical results at latency 9 cycles; randomized 1000-op comparison against a 64-bit reference model.
